// File: rtl/camera_handoff_scheduler.sv
// Two-camera recorder sequencer: film/standby handoff at buffer thresholds
// plus arbitration of the single download port for the held buffer.
module camera_handoff_scheduler #(
    parameter int STANDBY_PCT = 8,
    parameter int HANDOFF_PCT = 9,
    parameter int FLUSH_PCT   = 5,
    parameter int FULL_PCT    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] percent1,
    input  logic [3:0] percent2,
    input  logic       dlReq,
    input  logic       dlDone,
    output logic       film1,
    output logic       film2,
    output logic       standby1,
    output logic       standby2,
    output logic       flush1,
    output logic       flush2,
    output logic [1:0] dlGrant,
    output logic       active,
    output logic       overflow
);

    localparam logic [3:0] L_SB   = 4'(STANDBY_PCT);
    localparam logic [3:0] L_HO   = 4'(HANDOFF_PCT);
    localparam logic [3:0] L_FL   = 4'(FLUSH_PCT);
    localparam logic [3:0] L_FULL = 4'(FULL_PCT);
    localparam logic [3:0] L_MAX  = 4'd10;

    typedef enum logic [1:0] {
        P_IDLE,
        P_FILM,
        P_STANDBY
    } pstate_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HELD,
        S_DL
    } sstate_t;

    pstate_t    r_pstate, w_pnext;
    sstate_t    r_sstate, w_snext;
    logic       r_active, w_act_next;
    logic [1:0] r_flush, w_flush_next;
    logic       r_overflow, w_ovf_next;
    logic [3:0] w_raw, w_pa;

    assign w_raw = r_active ? percent2 : percent1;
    assign w_pa  = (w_raw > L_MAX) ? L_MAX : w_raw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pstate   <= P_IDLE;
            r_sstate   <= S_EMPTY;
            r_active   <= 1'b0;
            r_flush    <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_pstate   <= w_pnext;
            r_sstate   <= w_snext;
            r_active   <= w_act_next;
            r_flush    <= w_flush_next;
            r_overflow <= w_ovf_next;
        end
    end

    always_comb begin
        w_pnext      = r_pstate;
        w_snext      = r_sstate;
        w_act_next   = r_active;
        w_flush_next = 2'b00;
        w_ovf_next   = r_overflow;

        if (w_pa >= L_FULL && r_sstate != S_EMPTY)
            w_ovf_next = 1'b1;

        // Download request beats the flush threshold in the same cycle
        case (r_sstate)
            S_HELD: begin
                if (dlReq)
                    w_snext = S_DL;
                else if (w_pa >= L_FL) begin
                    w_snext      = S_EMPTY;
                    w_flush_next = r_active ? 2'b01 : 2'b10;
                end
            end
            S_DL: begin
                if (dlDone)
                    w_snext = S_EMPTY;
            end
            default: w_snext = r_sstate;
        endcase

        case (r_pstate)
            P_IDLE: begin
                if (start) begin
                    w_pnext    = P_FILM;
                    w_act_next = 1'b0;
                end
            end
            P_FILM: begin
                if (w_pa >= L_SB && r_sstate == S_EMPTY)
                    w_pnext = P_STANDBY;
            end
            P_STANDBY: begin
                if (w_pa >= L_HO) begin
                    w_pnext    = P_FILM;
                    w_act_next = ~r_active;
                    w_snext    = S_HELD;
                end
            end
            default: w_pnext = P_IDLE;
        endcase
    end

    assign film1    = (r_pstate != P_IDLE) && !r_active;
    assign film2    = (r_pstate != P_IDLE) && r_active;
    assign standby1 = (r_pstate == P_STANDBY) && r_active;
    assign standby2 = (r_pstate == P_STANDBY) && !r_active;
    assign flush1   = r_flush[0];
    assign flush2   = r_flush[1];
    assign dlGrant  = (r_sstate == S_DL) ? (r_active ? 2'b01 : 2'b10)
                                         : 2'b00;
    assign active   = r_active;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_camera_handoff_scheduler.sv
// Directed vector table, async-reset sequence and randomized run
// checked against a behavioural model of the recorder sequencing rules.
module tb_camera_handoff_scheduler;

    logic       clock, reset, start, dlReq, dlDone;
    logic [3:0] percent1, percent2;
    logic       film1, film2, standby1, standby2, flush1, flush2;
    logic [1:0] dlGrant;
    logic       active, overflow;

    int n_cmp = 0;
    int n_fail = 0;

    camera_handoff_scheduler dut (
        .clock(clock), .reset(reset), .start(start),
        .percent1(percent1), .percent2(percent2),
        .dlReq(dlReq), .dlDone(dlDone),
        .film1(film1), .film2(film2),
        .standby1(standby1), .standby2(standby2),
        .flush1(flush1), .flush2(flush2),
        .dlGrant(dlGrant), .active(active), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: recording on/off, standby phase, which camera
    // is primary, and the status of the other camera's held buffer.
    bit m_on, m_sb, m_act, m_ovf, m_fl1, m_fl2;
    int m_buf; // 0 = empty, 1 = held, 2 = downloading

    function automatic int clamp10(input logic [3:0] p);
        return (p > 4'd10) ? 10 : int'(p);
    endfunction

    task automatic model_reset();
        m_on = 0; m_sb = 0; m_act = 0; m_ovf = 0;
        m_fl1 = 0; m_fl2 = 0; m_buf = 0;
    endtask

    task automatic model_edge();
        int  pa, old_buf;
        bit  old_sb, old_on;
        pa      = clamp10(m_act ? percent2 : percent1);
        old_buf = m_buf;
        old_sb  = m_sb;
        old_on  = m_on;
        m_fl1   = 0;
        m_fl2   = 0;
        if (pa >= 10 && old_buf != 0) m_ovf = 1;
        if (old_buf == 1) begin
            if (dlReq) m_buf = 2;
            else if (pa >= 5) begin
                m_buf = 0;
                if (m_act) m_fl1 = 1; else m_fl2 = 1;
            end
        end else if (old_buf == 2 && dlDone) begin
            m_buf = 0;
        end
        if (!old_on) begin
            if (start) begin m_on = 1; m_act = 0; end
        end else if (!old_sb) begin
            if (pa >= 8 && old_buf == 0) m_sb = 1;
        end else if (pa >= 9) begin
            m_sb  = 0;
            m_act = ~m_act;
            m_buf = 1;
        end
    endtask

    function automatic logic [9:0] model_vec();
        logic [1:0] g;
        g = (m_buf == 2) ? (m_act ? 2'b01 : 2'b10) : 2'b00;
        return {m_on && !m_act, m_on && m_act, m_sb && m_act,
                m_sb && !m_act, m_fl1, m_fl2, g, m_act, m_ovf};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {film1, film2, standby1, standby2, flush1, flush2,
                dlGrant, active, overflow};
    endfunction

    task automatic check(input string nm, input logic [9:0] exp);
        logic [9:0] got;
        got = dut_vec();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (f1f2 s1s2 fl1fl2 g act ovf)",
                     nm, got, exp);
        end
    endtask

    task automatic edge_only();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic async_reset(input string nm);
        #2 reset = 1'b1;
        model_reset();
        #1 check(nm, 10'b0);
        reset = 1'b0;
    endtask

    typedef struct {
        string      nm;
        logic       st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       rq;
        logic       dn;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{"start",        1, 0,  0,  0, 0, 10'b10_00_00_00_0_0};
        tbl[1]  = '{"film1_hold",   0, 5,  0,  0, 0, 10'b10_00_00_00_0_0};
        tbl[2]  = '{"standby2",     0, 8,  0,  0, 0, 10'b10_01_00_00_0_0};
        tbl[3]  = '{"standby2_hld", 0, 8,  0,  0, 0, 10'b10_01_00_00_0_0};
        tbl[4]  = '{"handoff_to2",  0, 9,  0,  0, 0, 10'b01_00_00_00_1_0};
        tbl[5]  = '{"held_below",   0, 10, 3,  0, 0, 10'b01_00_00_00_1_0};
        tbl[6]  = '{"flush1",       0, 10, 5,  0, 0, 10'b01_00_10_00_1_0};
        tbl[7]  = '{"flush1_end",   0, 10, 5,  0, 0, 10'b01_00_00_00_1_0};
        tbl[8]  = '{"standby1",     0, 10, 8,  0, 0, 10'b01_10_00_00_1_0};
        tbl[9]  = '{"handoff_to1",  0, 0,  9,  0, 0, 10'b10_00_00_00_0_0};
        tbl[10] = '{"dl_beats_fl",  0, 5,  9,  1, 0, 10'b10_00_00_10_0_0};
        tbl[11] = '{"no_sb_in_dl",  0, 9,  9,  0, 0, 10'b10_00_00_10_0_0};
        tbl[12] = '{"dl_done",      0, 9,  9,  0, 1, 10'b10_00_00_00_0_0};
        tbl[13] = '{"sb_after_dl",  0, 9,  9,  0, 0, 10'b10_01_00_00_0_0};
        tbl[14] = '{"ho_min_1cyc",  0, 9,  0,  0, 0, 10'b01_00_00_00_1_0};
        tbl[15] = '{"dl_done_ign",  0, 0,  2,  1, 1, 10'b01_00_00_01_1_0};
        tbl[16] = '{"overflow",     0, 0,  10, 0, 0, 10'b01_00_00_01_1_1};
        tbl[17] = '{"clamp15",      0, 0,  15, 0, 0, 10'b01_00_00_01_1_1};
        tbl[18] = '{"ovf_sticky",   0, 0,  10, 0, 1, 10'b01_00_00_00_1_1};
        tbl[19] = '{"sb_full",      0, 0,  10, 0, 0, 10'b01_10_00_00_1_1};
        tbl[20] = '{"start_ignored",1, 0,  7,  0, 0, 10'b01_10_00_00_1_1};

        reset = 1'b1; start = 0; dlReq = 0; dlDone = 0;
        percent1 = 0; percent2 = 0;
        model_reset();
        #12 check("reset_state", 10'b0);
        reset = 1'b0;
        edge_only();
        check("idle_no_start", 10'b0);

        foreach (tbl[i]) begin
            start = tbl[i].st; percent1 = tbl[i].p1; percent2 = tbl[i].p2;
            dlReq = tbl[i].rq; dlDone = tbl[i].dn;
            edge_only();
            check(tbl[i].nm, tbl[i].exp);
        end

        // Mid-download asynchronous reset, then restart requirement
        start = 0; dlReq = 0; dlDone = 0; percent1 = 0; percent2 = 0;
        async_reset("reset_clear");
        start = 1; edge_only();
        percent1 = 8; start = 0; edge_only();
        percent1 = 9; edge_only();
        percent2 = 1; dlReq = 1; edge_only();
        dlReq = 0;
        check("pre_reset_dl", 10'b01_00_00_01_1_0);
        async_reset("async_rst_dl");
        edge_only();
        check("needs_start", 10'b0);
        start = 1; edge_only();
        check("restart", 10'b10_00_00_00_0_0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            percent1 = 4'($urandom_range(0, 15));
            percent2 = 4'($urandom_range(0, 15));
            dlReq    = ($urandom_range(0, 3) == 0);
            dlDone   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 400) == 0) begin
                async_reset("rand_reset");
            end else begin
                edge_only();
                check("random", model_vec());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
